// File: rtl/elv_pkg.sv
// elv_pkg: shared types and constants for the elevator call scheduler.
// Direction encoding matches the scheduler's dir output.
package elv_pkg;

    localparam int N_FLOORS_DEFAULT = 5;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        UP   = 2'b01,
        DOWN = 2'b10
    } dir_e;

    localparam logic [1:0] ELV_UP   = 2'b01;
    localparam logic [1:0] ELV_DOWN = 2'b10;
    localparam logic [1:0] ELV_STOP = 2'b11;

endpackage

// File: rtl/elv_scan_pick.sv
// elv_scan_pick: picks a one-hot floor from a request mask on one side
// of the current floor, either nearest or farthest.
module elv_scan_pick
    import elv_pkg::*;
#(
    parameter int N = N_FLOORS_DEFAULT
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] cur,
    input  logic         up_dir,
    input  logic         far,
    output logic [N-1:0] pick,
    output logic         any
);

    logic [N-1:0] side;
    logic [N-1:0] cand;
    logic         lowest;

    assign cand   = req & side;
    assign any    = |cand;
    assign lowest = up_dir ^ far;

    // Floors strictly above (or below) the one-hot current floor
    always_comb begin
        side = '0;
        if (up_dir) begin
            for (int i = 1; i < N; i++) begin
                side[i] = side[i-1] | cur[i-1];
            end
        end else begin
            for (int i = N - 2; i >= 0; i--) begin
                side[i] = side[i+1] | cur[i+1];
            end
        end
    end

    // Last hit wins, so scan order selects lowest or highest candidate
    always_comb begin
        pick = '0;
        if (lowest) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (cand[i]) pick = N'(1) << i;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (cand[i]) pick = N'(1) << i;
            end
        end
    end

endmodule

// File: rtl/elv_call_scheduler.sv
// elv_call_scheduler: latches hall/cabin calls, runs a SCAN direction
// FSM and drives the registered one-hot target floor.
module elv_call_scheduler
    import elv_pkg::*;
#(
    parameter int N_FLOORS = N_FLOORS_DEFAULT
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [N_FLOORS-2:0] up,
    input  logic [N_FLOORS-2:0] down,
    input  logic [N_FLOORS-1:0] car_call,
    input  logic                emergency,
    input  logic [N_FLOORS-1:0] current_floor,
    input  logic [N_FLOORS-1:0] door_control,
    input  logic [1:0]          elv_status,
    output logic [N_FLOORS-1:0] target_floor,
    output logic [1:0]          dir,
    output logic [N_FLOORS-2:0] up_pending,
    output logic [N_FLOORS-2:0] down_pending,
    output logic [N_FLOORS-1:0] car_pending
);

    localparam int N = N_FLOORS;

    logic [N-2:0] up_q, up_d;
    logic [N-2:0] down_q, down_d;
    logic [N-1:0] car_q, car_d;
    logic [N-1:0] tgt_q, tgt_d;
    dir_e         dir_q, dir_d;

    logic [N-1:0] up_ext, dn_ext, all_q;
    logic [N-1:0] abv_m, blw_m, above_f;
    logic [N-1:0] prim_req, rev_req;
    logic [N-1:0] prim_pick, rev_pick;
    logic         prim_any, rev_any;
    logic         any_above, any_below;
    logic         pos_ok, go_up;
    logic         unused_status;

    // Motion status carries no information the flush needs
    assign unused_status = (elv_status == ELV_STOP) ^ rev_any;

    assign up_ext    = {1'b0, up_q};
    assign dn_ext    = {down_q, 1'b0};
    assign all_q     = car_q | up_ext | dn_ext;
    assign pos_ok    = $onehot(current_floor);
    assign any_above = |(all_q & abv_m);
    assign any_below = |(all_q & blw_m);

    // Position masks and "any call above floor f" for down-call retirement
    always_comb begin
        abv_m   = '0;
        blw_m   = '0;
        above_f = '0;
        for (int i = 1; i < N; i++) begin
            abv_m[i] = abv_m[i-1] | current_floor[i-1];
        end
        for (int i = N - 2; i >= 0; i--) begin
            blw_m[i]   = blw_m[i+1] | current_floor[i+1];
            above_f[i] = above_f[i+1] | all_q[i+1];
        end
    end

    // Latch presses and retire served calls; clear beats set
    always_comb begin
        up_d   = '0;
        down_d = '0;
        car_d  = '0;
        if (!emergency) begin
            car_d = (car_q | car_call) & ~door_control;
            for (int i = 0; i < N - 1; i++) begin
                up_d[i] = (up_q[i] | up[i])
                    & ~(door_control[i] && dir_q != DOWN);
                down_d[i] = (down_q[i] | down[i])
                    & ~(door_control[i+1]
                        && (dir_q != UP || !above_f[i+1]));
            end
        end
    end

    // SCAN direction; holds while the car position is unknown
    always_comb begin
        dir_d = dir_q;
        if (emergency) begin
            dir_d = IDLE;
        end else if (pos_ok) begin
            case (dir_q)
                UP:
                    dir_d = any_above ? UP
                          : (any_below ? DOWN : IDLE);
                DOWN:
                    dir_d = any_below ? DOWN
                          : (any_above ? UP : IDLE);
                default:
                    dir_d = any_above ? UP
                          : (any_below ? DOWN : IDLE);
            endcase
        end
    end

    assign go_up    = (dir_d == UP);
    assign prim_req = car_q | (go_up ? up_ext : dn_ext);
    assign rev_req  = go_up ? dn_ext : up_ext;

    elv_scan_pick #(.N(N)) u_prim (
        .req    (prim_req),
        .cur    (current_floor),
        .up_dir (go_up),
        .far    (1'b0),
        .pick   (prim_pick),
        .any    (prim_any)
    );

    elv_scan_pick #(.N(N)) u_rev (
        .req    (rev_req),
        .cur    (current_floor),
        .up_dir (go_up),
        .far    (1'b1),
        .pick   (rev_pick),
        .any    (rev_any)
    );

    // Same-direction calls first, else the farthest reversing call
    always_comb begin
        tgt_d = tgt_q;
        if (emergency) begin
            tgt_d = '0;
        end else if (pos_ok) begin
            case (dir_d)
                UP, DOWN:
                    tgt_d = prim_any ? prim_pick : rev_pick;
                default:
                    tgt_d = |(all_q & current_floor)
                          ? current_floor : '0;
            endcase
        end
    end

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            up_q   <= '0;
            down_q <= '0;
            car_q  <= '0;
            tgt_q  <= '0;
            dir_q  <= IDLE;
        end else begin
            up_q   <= up_d;
            down_q <= down_d;
            car_q  <= car_d;
            tgt_q  <= tgt_d;
            dir_q  <= dir_d;
        end
    end

    assign target_floor = tgt_q;
    assign dir          = dir_q;
    assign up_pending   = up_q;
    assign down_pending = down_q;
    assign car_pending  = car_q;

endmodule

// File: tb/tb_elv_call_scheduler.sv
// tb_elv_call_scheduler: directed scenario tasks with hand-computed
// expectations for the elevator call scheduler.
module tb_elv_call_scheduler;

    logic       clk;
    logic       reset_n;
    logic [3:0] up;
    logic [3:0] down;
    logic [4:0] car_call;
    logic       emergency;
    logic [4:0] current_floor;
    logic [4:0] door_control;
    logic [1:0] elv_status;
    logic [4:0] target_floor;
    logic [1:0] dir;
    logic [3:0] up_pending;
    logic [3:0] down_pending;
    logic [4:0] car_pending;

    int vectors = 0;
    int miscompares = 0;

    elv_call_scheduler dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .up            (up),
        .down          (down),
        .car_call      (car_call),
        .emergency     (emergency),
        .current_floor (current_floor),
        .door_control  (door_control),
        .elv_status    (elv_status),
        .target_floor  (target_floor),
        .dir           (dir),
        .up_pending    (up_pending),
        .down_pending  (down_pending),
        .car_pending   (car_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n       = 1'b0;
        up            = '0;
        down          = '0;
        car_call      = '0;
        emergency     = 1'b0;
        current_floor = '0;
        door_control  = '0;
        elv_status    = 2'b11;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({target_floor, dir, up_pending, down_pending, car_pending}
            !== 20'h0) begin
            miscompares++;
            $display("FAIL reset_outs: tgt=%b dir=%b up=%b dn=%b car=%b want 0",
                     target_floor, dir, up_pending, down_pending, car_pending);
        end
    endtask

    task automatic test_up_press();
        do_reset();
        current_floor = 5'b00001;
        up = 4'b0100;
        step();
        up = '0;
        vectors++;
        if ({up_pending, dir, target_floor} !== {4'b0100, 2'b00, 5'b00000}) begin
            miscompares++;
            $display("FAIL up_press_edge1: up=%b dir=%b tgt=%b want 0100/00/00000",
                     up_pending, dir, target_floor);
        end
        step();
        vectors++;
        if ({up_pending, dir, target_floor} !== {4'b0100, 2'b01, 5'b00100}) begin
            miscompares++;
            $display("FAIL up_press_edge2: up=%b dir=%b tgt=%b want 0100/01/00100",
                     up_pending, dir, target_floor);
        end
    endtask

    task automatic test_car_reverse();
        do_reset();
        current_floor = 5'b00100;
        car_call = 5'b10001;
        step();
        car_call = '0;
        vectors++;
        if (car_pending !== 5'b10001) begin
            miscompares++;
            $display("FAIL car_latch: car=%b want 10001", car_pending);
        end
        step();
        vectors++;
        if ({dir, target_floor} !== {2'b01, 5'b10000}) begin
            miscompares++;
            $display("FAIL car_up_tgt: dir=%b tgt=%b want 01/10000",
                     dir, target_floor);
        end
        current_floor = 5'b10000;
        door_control = 5'b10000;
        step();
        door_control = '0;
        vectors++;
        if (car_pending !== 5'b00001) begin
            miscompares++;
            $display("FAIL car_serve: car=%b want 00001", car_pending);
        end
        step();
        vectors++;
        if ({dir, target_floor} !== {2'b10, 5'b00001}) begin
            miscompares++;
            $display("FAIL car_rev_tgt: dir=%b tgt=%b want 10/00001",
                     dir, target_floor);
        end
    endtask

    task automatic test_top_down_call();
        do_reset();
        current_floor = 5'b00001;
        down = 4'b1000;
        step();
        down = '0;
        step();
        vectors++;
        if ({dir, target_floor} !== {2'b01, 5'b10000}) begin
            miscompares++;
            $display("FAIL topdn_tgt: dir=%b tgt=%b want 01/10000",
                     dir, target_floor);
        end
        current_floor = 5'b10000;
        door_control = 5'b10000;
        step();
        door_control = '0;
        vectors++;
        if (down_pending !== 4'b0000) begin
            miscompares++;
            $display("FAIL topdn_serve: dn=%b want 0000", down_pending);
        end
        step();
        vectors++;
        if ({dir, target_floor} !== {2'b00, 5'b00000}) begin
            miscompares++;
            $display("FAIL topdn_idle: dir=%b tgt=%b want 00/00000",
                     dir, target_floor);
        end
    endtask

    task automatic test_open_door_press();
        do_reset();
        current_floor = 5'b00010;
        door_control = 5'b00010;
        up = 4'b0010;
        down = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if ({up_pending, down_pending, dir, target_floor} !== 15'h0) begin
                miscompares++;
                $display("FAIL door_press[%0d]: up=%b dn=%b dir=%b tgt=%b want 0",
                         i, up_pending, down_pending, dir, target_floor);
            end
        end
        up = '0;
        down = '0;
        door_control = '0;
    endtask

    task automatic test_scan_pick();
        do_reset();
        current_floor = 5'b00100;
        car_call = 5'b01010;
        step();
        car_call = '0;
        step();
        vectors++;
        if ({dir, target_floor} !== {2'b01, 5'b01000}) begin
            miscompares++;
            $display("FAIL scan_up_wins: dir=%b tgt=%b want 01/01000",
                     dir, target_floor);
        end
        do_reset();
        current_floor = 5'b10000;
        up = 4'b0011;
        step();
        up = '0;
        step();
        vectors++;
        if ({dir, target_floor} !== {2'b10, 5'b00001}) begin
            miscompares++;
            $display("FAIL scan_rev_low: dir=%b tgt=%b want 10/00001",
                     dir, target_floor);
        end
        do_reset();
        current_floor = 5'b00001;
        up = 4'b1000;
        down = 4'b0011;
        step();
        up = '0;
        down = '0;
        step();
        vectors++;
        if ({dir, target_floor} !== {2'b01, 5'b01000}) begin
            miscompares++;
            $display("FAIL scan_prim_first: dir=%b tgt=%b want 01/01000",
                     dir, target_floor);
        end
        do_reset();
        current_floor = 5'b00100;
        car_call = 5'b00100;
        step();
        car_call = '0;
        step();
        vectors++;
        if ({dir, target_floor} !== {2'b00, 5'b00100}) begin
            miscompares++;
            $display("FAIL scan_idle_here: dir=%b tgt=%b want 00/00100",
                     dir, target_floor);
        end
    endtask

    task automatic test_invalid_pos();
        do_reset();
        current_floor = 5'b00001;
        car_call = 5'b00100;
        step();
        car_call = '0;
        step();
        current_floor = 5'b00000;
        car_call = 5'b10000;
        step();
        car_call = '0;
        vectors++;
        if ({car_pending, dir, target_floor} !== {5'b10100, 2'b01, 5'b00100}) begin
            miscompares++;
            $display("FAIL inval_between: car=%b dir=%b tgt=%b want 10100/01/00100",
                     car_pending, dir, target_floor);
        end
        current_floor = 5'b00011;
        step();
        vectors++;
        if ({dir, target_floor} !== {2'b01, 5'b00100}) begin
            miscompares++;
            $display("FAIL inval_multi: dir=%b tgt=%b want 01/00100",
                     dir, target_floor);
        end
    endtask

    task automatic test_emergency();
        do_reset();
        current_floor = 5'b00001;
        up = 4'b0101;
        down = 4'b1000;
        car_call = 5'b00110;
        step();
        vectors++;
        if ({up_pending, down_pending, car_pending}
            !== {4'b0101, 4'b1000, 5'b00110}) begin
            miscompares++;
            $display("FAIL emg_preload: up=%b dn=%b car=%b want 0101/1000/00110",
                     up_pending, down_pending, car_pending);
        end
        emergency = 1'b1;
        up = 4'b1111;
        down = 4'b1111;
        car_call = 5'b11111;
        for (int i = 0; i < 2; i++) begin
            step();
            vectors++;
            if ({up_pending, down_pending, car_pending, dir, target_floor}
                !== 20'h0) begin
                miscompares++;
                $display("FAIL emg_flush[%0d]: up=%b dn=%b car=%b dir=%b tgt=%b want 0",
                         i, up_pending, down_pending, car_pending, dir, target_floor);
            end
        end
        emergency = 1'b0;
        up = 4'b0010;
        down = '0;
        car_call = '0;
        step();
        up = '0;
        vectors++;
        if (up_pending !== 4'b0010) begin
            miscompares++;
            $display("FAIL emg_relatch: up=%b want 0010", up_pending);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        current_floor = 5'b00001;
        car_call = 5'b01000;
        step();
        car_call = '0;
        step();
        vectors++;
        if ({dir, target_floor} !== {2'b01, 5'b01000}) begin
            miscompares++;
            $display("FAIL arst_setup: dir=%b tgt=%b want 01/01000",
                     dir, target_floor);
        end
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({target_floor, dir, up_pending, down_pending, car_pending}
            !== 20'h0) begin
            miscompares++;
            $display("FAIL arst_now: tgt=%b dir=%b car=%b want 0",
                     target_floor, dir, car_pending);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_up_press();
        test_car_reverse();
        test_top_down_call();
        test_open_door_press();
        test_scan_pick();
        test_invalid_pos();
        test_emergency();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
